gs_sweep_averager: RTL and testbench

Coherent sweep averager for the PEATC raw signal. It sits directly upstream of the GS state machine and replaces the simulated raw-signal source. It accumulates 2^n stimulus-locked sweeps of 256 signed samples into an internal accumulator RAM. When averaging completes it raises RawDataReady, and the GS state machine then reads the averaged samples by 8-bit address.

---
 rtl/gs_pkg.sv | 18 +
 rtl/gs_acc_ram.sv | 29 ++
 rtl/gs_sweep_averager.sv | 158 +++++++++++++++
 tb/tb_gs_sweep_averager.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared types and constants for the GS coherent sweep averager.
package gs_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 8;
  localparam int MAX_LOG2 = 8;
  localparam int ACC_W    = SAMPLE_W + MAX_LOG2;

  // Largest sweep exponent accepted; larger requests are clamped to this.
  localparam logic [3:0] N_CLAMP = 4'(MAX_LOG2);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, DONE} gs_state_e;

  function automatic logic [3:0] clamp_n(input logic [3:0] n);
    return (n > N_CLAMP) ? N_CLAMP : n;
  endfunction

endpackage

// File: rtl/gs_acc_ram.sv
// 256 x ACC_W simple dual-port accumulator RAM, synchronous read and write.
// Contents are never cleared; only the read data register is reset.
module gs_acc_ram
  import gs_pkg::*;
(
  input  logic              iClk,
  input  logic              iReset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ACC_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ACC_W-1:0]  rdata_q
);

  logic [ACC_W-1:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge iClk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; data register holds when re is low.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset)  rdata_q <= '0;
    else if (re)  rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/gs_sweep_averager.sv
// Coherent sweep averager: sums 2^n stimulus-locked sweeps of 256 samples
// into gs_acc_ram and serves the average (sum >>> n) to the GS state machine.
// Optional: define GS_AVG_SWEEP_CNT_EN to expose o9SweepCount.
module gs_sweep_averager
  import gs_pkg::*;
(
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [3:0]          i4SweepsLog2,
  input  logic                iSweepSync,
  input  logic                iSampleValid,
  input  logic [SAMPLE_W-1:0] i16Sample,
  output logic                oBusy,
  output logic                oGS_RawDataReady,
  output logic                oSyncErr,
  input  logic                iRead_en,
  input  logic [ADDR_W-1:0]   i8Addr,
  output logic [SAMPLE_W-1:0] o16Reg
`ifdef GS_AVG_SWEEP_CNT_EN
  ,
  output logic [8:0]          o9SweepCount
`endif
);

  gs_state_e           state_q, state_d;
  logic [3:0]          n_q, n_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                done_pend_q, done_pend_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_first_q, wr_first_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_sample_q, wr_sample_d;
  logic                accept;
  logic [ACC_W-1:0]    rd_data, wr_data, wr_sext;

  // Control FSM next state plus the read-modify-write issue stage.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    err_d       = err_q;
    done_pend_d = done_pend_q;
    accept      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          state_d     = ARM;
          n_d         = clamp_n(i4SweepsLog2);
          cnt_d       = '0;
          addr_d      = '0;
          err_d       = 1'b0;
          done_pend_d = 1'b0;
        end
      end
      ARM: begin
        // A sample coincident with the sync is sample 0 of the sweep.
        if (iSweepSync) begin
          state_d = ACCUM;
          accept  = iSampleValid;
        end
      end
      ACCUM: begin
        // done_pend gives the last write-back one cycle before DONE, so a
        // read issued on the first DONE cycle already sees the final sum.
        if (done_pend_q) begin
          state_d     = DONE;
          done_pend_d = 1'b0;
        end else begin
          if (iSweepSync && addr_q != '1) err_d = 1'b1;
          accept = iSampleValid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      addr_d = addr_q + 1'b1;
      if (addr_q == '1) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == (9'd1 << n_q)) done_pend_d = 1'b1;
        else                        state_d     = ARM;
      end
    end
    wr_en_d     = accept;
    wr_addr_d   = addr_q;
    wr_first_d  = (cnt_q == '0);
    wr_sample_d = i16Sample;
    busy_d      = (state_d == ARM) || (state_d == ACCUM);
    ready_d     = (state_d == DONE);
  end

  // State, counters, write-back pipeline and registered status outputs.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      done_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_first_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_sample_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      done_pend_q <= done_pend_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_first_q  <= wr_first_d;
      wr_addr_q   <= wr_addr_d;
      wr_sample_q <= wr_sample_d;
    end
  end

  // Write-back: first sweep overwrites stale RAM, later sweeps add.
  always_comb begin
    wr_sext = {{MAX_LOG2{wr_sample_q[SAMPLE_W-1]}}, wr_sample_q};
    wr_data = wr_first_q ? wr_sext : rd_data + wr_sext;
  end

  // Accumulation owns the read port whenever it needs it.
  gs_acc_ram u_ram (
    .iClk    (iClk),
    .iReset  (iReset),
    .we      (wr_en_q),
    .waddr   (wr_addr_q),
    .wdata   (wr_data),
    .re      (accept | iRead_en),
    .raddr   (accept ? addr_q : i8Addr),
    .rdata_q (rd_data)
  );

  assign oBusy            = busy_q;
  assign oGS_RawDataReady = ready_q;
  assign oSyncErr         = err_q;
  // RAM data register is the output register; the divide is a shift.
  assign o16Reg           = SAMPLE_W'($signed(rd_data) >>> n_q);

`ifdef GS_AVG_SWEEP_CNT_EN
  assign o9SweepCount = cnt_q;
`else
  // Sweep count stays internal, used only for termination.
`endif

endmodule

// File: tb/tb_gs_sweep_averager.sv
// Directed bench for gs_sweep_averager: read-back tables plus hand sequences.
module tb_gs_sweep_averager;

  logic        iClk = 1'b0;
  logic        iReset, iStart, iSweepSync, iSampleValid, iRead_en;
  logic [3:0]  i4SweepsLog2;
  logic [15:0] i16Sample;
  logic [7:0]  i8Addr;
  logic        oBusy, oGS_RawDataReady, oSyncErr;
  logic [15:0] o16Reg;
`ifdef GS_AVG_SWEEP_CNT_EN
  logic [8:0]  o9SweepCount;
`endif

  gs_sweep_averager dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .i4SweepsLog2(i4SweepsLog2),
    .iSweepSync(iSweepSync), .iSampleValid(iSampleValid), .i16Sample(i16Sample),
    .oBusy(oBusy), .oGS_RawDataReady(oGS_RawDataReady), .oSyncErr(oSyncErr),
    .iRead_en(iRead_en), .i8Addr(i8Addr), .o16Reg(o16Reg)
`ifdef GS_AVG_SWEEP_CNT_EN
    , .o9SweepCount(o9SweepCount)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {int test; int addr; int exp;} rd_vec_t;
  rd_vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic start_run(input int n);
    @(negedge iClk); iStart = 1'b1; i4SweepsLog2 = 4'(n);
    @(negedge iClk); iStart = 1'b0;
  endtask

  // mode 0: sample = address; mode 1: constant val. Extra sync / start pulses
  // are injected at the given addresses (-1 = none).
  task automatic sweep(input int mode, input int val, input int sync_at, input int start_at);
    for (int a = 0; a < 256; a++) begin
      @(negedge iClk);
      iSampleValid = 1'b1;
      iSweepSync   = (a == 0) || (a == sync_at);
      iStart       = (a == start_at);
      i16Sample    = (mode == 0) ? 16'(a) : 16'(val);
    end
    @(negedge iClk); iSampleValid = 1'b0; iSweepSync = 1'b0; iStart = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k = 0;
    while (!oGS_RawDataReady && k < budget) begin @(negedge iClk); k++; end
    check(name, int'(oGS_RawDataReady), 1);
  endtask

  task automatic run_reads(input int test);
    foreach (tbl[i]) if (tbl[i].test == test) begin
      @(negedge iClk); iRead_en = 1'b1; i8Addr = 8'(tbl[i].addr);
      @(negedge iClk); iRead_en = 1'b0;
      check($sformatf("t%0d rd[%0d]", test, tbl[i].addr), int'($signed(o16Reg)), tbl[i].exp);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{1, 37, 37}, '{1, 0, 0}, '{1, 255, 255}, '{1, 128, 128},
      '{2, 0, -102}, '{2, 1, -102}, '{2, 100, -102}, '{2, 255, -102},
      '{3, 99, 50}, '{3, 100, 50}, '{3, 101, 50}, '{3, 255, 50},
      '{4, 0, 32767}, '{4, 77, 32767}, '{4, 255, 32767},
      '{5, 0, 15}, '{5, 50, 15}, '{5, 99, 15}, '{5, 255, 15},
      '{6, 3, -1}, '{6, 200, -1},
      '{7, 10, 77}
    };
    iReset = 1'b0; iStart = 1'b0; iSweepSync = 1'b0; iSampleValid = 1'b0;
    iRead_en = 1'b0; i4SweepsLog2 = '0; i16Sample = '0; i8Addr = '0;
    repeat (3) @(negedge iClk);
    check("rst busy", int'(oBusy), 0);
    check("rst ready", int'(oGS_RawDataReady), 0);
    check("rst syncerr", int'(oSyncErr), 0);
    check("rst o16Reg", int'(o16Reg), 0);
    iReset = 1'b1;

    // 1: single sweep, sample = address
    start_run(0);
    check("t1 busy", int'(oBusy), 1);
    sweep(0, 0, -1, -1);
    wait_ready("t1 ready", 2);
    check("t1 busy done", int'(oBusy), 0);
    run_reads(1);
    @(negedge iClk); i8Addr = 8'd5;
    @(negedge iClk);
    check("t1 hold", int'(o16Reg), 128);
`ifdef GS_AVG_SWEEP_CNT_EN
    check("t1 count", int'(o9SweepCount), 1);
`endif

    // 2: four negative sweeps, floor on the shift
    start_run(2);
    sweep(1, -100, -1, -1); sweep(1, -101, -1, -1);
    sweep(1, -102, -1, -1); sweep(1, -103, -1, -1);
    wait_ready("t2 ready", 2);
    check("t2 syncerr", int'(oSyncErr), 0);
    run_reads(2);

    // 3: stray sync mid-sweep sets sticky error, result intact
    start_run(1);
    sweep(1, 50, -1, -1);
    check("t3 syncerr pre", int'(oSyncErr), 0);
    sweep(1, 51, 100, -1);
    check("t3 syncerr", int'(oSyncErr), 1);
    wait_ready("t3 ready", 2);
    run_reads(3);

    // 4: n=15 clamps to 256 full-scale sweeps
    start_run(15);
    for (int s = 0; s < 256; s++) sweep(1, 32767, -1, -1);
    wait_ready("t4 ready", 2);
    run_reads(4);
`ifdef GS_AVG_SWEEP_CNT_EN
    check("t4 count", int'(o9SweepCount), 256);
`endif

    // 5: reset mid-ACCUM, then a fresh n=1 run over stale RAM
    start_run(1);
    for (int a = 0; a < 100; a++) begin
      @(negedge iClk); iSampleValid = 1'b1; iSweepSync = (a == 0); i16Sample = 16'd999;
    end
    @(negedge iClk); iSampleValid = 1'b0; iSweepSync = 1'b0; iReset = 1'b0;
    @(negedge iClk);
    check("t5 rst busy", int'(oBusy), 0);
    check("t5 rst ready", int'(oGS_RawDataReady), 0);
    iReset = 1'b1;
    start_run(1);
    sweep(1, 10, -1, -1); sweep(1, 20, -1, -1);
    wait_ready("t5 ready", 2);
    run_reads(5);

    // 6: iStart during ARM and ACCUM ignored
    start_run(1);
    i4SweepsLog2 = 4'd0;
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    sweep(1, 7, -1, 60);
    @(negedge iClk);
    check("t6 not ready", int'(oGS_RawDataReady), 0);
    check("t6 still busy", int'(oBusy), 1);
    sweep(1, -8, -1, -1);
    wait_ready("t6 ready", 2);
    run_reads(6);

    // 7: iStart in DONE restarts
    start_run(0);
    check("t7 ready drop", int'(oGS_RawDataReady), 0);
    check("t7 busy", int'(oBusy), 1);
    sweep(1, 77, -1, -1);
    wait_ready("t7 ready", 2);
    run_reads(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
